evg_v1_time_stamp_serializer: RTL and testbench

EVG_V1_TIME_STAMP_SERIALIZER -- requirements
Module: evg_v1_time_stamp_serializer

---
 rtl/evg_v1_pkg.sv | 20 ++
 rtl/evg_v1_time_stamp_serializer_if.sv | 9 +
 rtl/evg_v1_time_stamp_serializer_second_tick.sv | 27 ++
 rtl/evg_v1_time_stamp_serializer.sv | 163 ++++++++++++++++
 tb/tb_evg_v1_time_stamp_serializer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/evg_v1_pkg.sv
// Shared constants and FSM state type for the EVG v1 time-stamp serializer.
package evg_v1_pkg;

  localparam logic [7:0] EVT_SEC_BIT0  = 8'h70;
  localparam logic [7:0] EVT_SEC_BIT1  = 8'h71;
  localparam logic [7:0] EVT_SEC_LATCH = 8'h7D;

  typedef enum logic [1:0] {
    IDLE,
    SEND_LATCH,
    GAP,
    SEND_BIT
  } evg_state_t;

  // Event code carrying one seconds bit.
  function automatic logic [7:0] sec_bit_code(input logic b);
    return b ? EVT_SEC_BIT1 : EVT_SEC_BIT0;
  endfunction

endpackage

// File: rtl/evg_v1_time_stamp_serializer_if.sv
// Event handshake towards the downstream event mux.
interface evg_v1_time_stamp_serializer_if;
  logic       EvtValid;
  logic [7:0] EvtCode;
  logic       EvtReady;

  modport master (output EvtValid, output EvtCode, input EvtReady);
  modport slave  (input EvtValid, input EvtCode, output EvtReady);
endinterface

// File: rtl/evg_v1_time_stamp_serializer_second_tick.sv
// Sub-second down-counter; Tick is high for the one cycle the count is 0.
module evg_v1_second_tick #(
  parameter int unsigned CLKS_PER_SEC = 330556
) (
  input  logic Clock,
  input  logic Reset,
  output logic Tick
);

  localparam int unsigned CW = (CLKS_PER_SEC < 2) ? 1 : $clog2(CLKS_PER_SEC);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_SEC - 1);

  logic [CW-1:0] count;

  // Count down from CLKS_PER_SEC-1, reload after reaching zero.
  always_ff @(posedge Clock) begin
    if (Reset)
      count <= RELOAD;
    else if (count == '0)
      count <= RELOAD;
    else
      count <= count - CW'(1);
  end

  assign Tick = (count == '0);

endmodule

// File: rtl/evg_v1_time_stamp_serializer.sv
// Seconds counter and serializer: on every second emits 0x7D followed by the
// next seconds value, MSB first, as 0x70/0x71 events spaced by BIT_GAP.
module evg_v1_time_stamp_serializer
  import evg_v1_pkg::*;
#(
  parameter int unsigned CLKS_PER_SEC = 330556,
  parameter int unsigned BIT_GAP      = 16
) (
  input  logic                                  Clock,
  input  logic                                  Reset,
  input  logic                                  SecondsLoad,
  input  logic [31:0]                           SecondsLoadValue,
  input  logic                                  OverrunClear,
  evg_v1_time_stamp_serializer_if.master        evt,
  output logic [31:0]                           Seconds,
  output logic                                  Overrun
);

  localparam int unsigned GW = (BIT_GAP < 2) ? 1 : $clog2(BIT_GAP + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(BIT_GAP);

  evg_state_t    state;
  logic          tick;
  logic          tick_pending;
  logic          pend_any;
  logic          enter_latch;
  logic [31:0]   shift_reg;
  logic [4:0]    bit_idx;
  logic [GW-1:0] gap_cnt;

  evg_v1_second_tick #(.CLKS_PER_SEC(CLKS_PER_SEC)) u_tick (
    .Clock (Clock),
    .Reset (Reset),
    .Tick  (tick)
  );

  // A same-cycle Tick counts as pending so IDLE reaches SEND_LATCH one cycle after Tick.
  assign pend_any = tick_pending | tick;

  // Seconds count and the value to serialise (the one the next 0x7D makes current).
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Seconds   <= '0;
      shift_reg <= '0;
    end else begin
      if (SecondsLoad)
        Seconds <= SecondsLoadValue;
      else if (tick)
        Seconds <= Seconds + 32'd1;
      if (tick)
        shift_reg <= SecondsLoad ? (SecondsLoadValue + 32'd1) : (Seconds + 32'd2);
    end
  end

  // Sticky overrun: a second boundary while a serialisation is in flight; set beats clear.
  always_ff @(posedge Clock) begin
    if (Reset)
      Overrun <= 1'b0;
    else if (tick && (state != IDLE))
      Overrun <= 1'b1;
    else if (OverrunClear)
      Overrun <= 1'b0;
  end

  // Whether this cycle's transition lands in SEND_LATCH (consumes the pending tick).
  always_comb begin
    enter_latch = 1'b0;
    unique case (state)
      IDLE, SEND_LATCH, GAP: enter_latch = pend_any;
      SEND_BIT:              enter_latch = pend_any && evt.EvtReady && (bit_idx != '0);
      default:               enter_latch = 1'b0;
    endcase
  end

  // Tick capture, cleared on entry to SEND_LATCH.
  always_ff @(posedge Clock) begin
    if (Reset)
      tick_pending <= 1'b0;
    else
      tick_pending <= pend_any && !enter_latch;
  end

  // Serializer FSM with registered EvtValid/EvtCode; code is captured on entry
  // to a sending state so it stays stable even if shift_reg reloads meanwhile.
  // A tick while an unaccepted 0x7D is presented is absorbed by that 0x7D.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      bit_idx      <= 5'd31;
      gap_cnt      <= '0;
      evt.EvtValid <= 1'b0;
      evt.EvtCode  <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (pend_any) begin
            state        <= SEND_LATCH;
            evt.EvtValid <= 1'b1;
            evt.EvtCode  <= EVT_SEC_LATCH;
          end
        end

        SEND_LATCH: begin
          if (evt.EvtReady && !pend_any) begin
            bit_idx <= 5'd31;
            if (BIT_GAP == 0) begin
              state        <= SEND_BIT;
              evt.EvtValid <= 1'b1;
              evt.EvtCode  <= sec_bit_code(shift_reg[31]);
            end else begin
              state        <= GAP;
              gap_cnt      <= GAP_LOAD;
              evt.EvtValid <= 1'b0;
            end
          end
        end

        GAP: begin
          if (pend_any) begin
            state        <= SEND_LATCH;
            evt.EvtValid <= 1'b1;
            evt.EvtCode  <= EVT_SEC_LATCH;
          end else if (gap_cnt <= GW'(1)) begin
            state        <= SEND_BIT;
            evt.EvtValid <= 1'b1;
            evt.EvtCode  <= sec_bit_code(shift_reg[bit_idx]);
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end

        SEND_BIT: begin
          if (evt.EvtReady) begin
            if (bit_idx == '0) begin
              state        <= IDLE;
              evt.EvtValid <= 1'b0;
            end else if (pend_any) begin
              state        <= SEND_LATCH;
              evt.EvtValid <= 1'b1;
              evt.EvtCode  <= EVT_SEC_LATCH;
            end else begin
              bit_idx <= bit_idx - 5'd1;
              if (BIT_GAP == 0) begin
                evt.EvtValid <= 1'b1;
                evt.EvtCode  <= sec_bit_code(shift_reg[bit_idx - 5'd1]);
              end else begin
                state        <= GAP;
                gap_cnt      <= GAP_LOAD;
                evt.EvtValid <= 1'b0;
              end
            end
          end
        end

        default: begin
          state        <= IDLE;
          evt.EvtValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_evg_v1_time_stamp_serializer.sv
// Bench for the time-stamp serializer: three instances with different
// CLKS_PER_SEC/BIT_GAP, expected event codes queued and checked on transfer.
module tb_evg_v1_time_stamp_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  // Instance A: 100 clocks/s, gap 2
  logic a_rst, a_load, a_clr, a_ovr;
  logic [31:0] a_lv, a_sec;
  evg_v1_time_stamp_serializer_if a_if ();
  evg_v1_time_stamp_serializer #(.CLKS_PER_SEC(100), .BIT_GAP(2)) dut_a (
    .Clock(clk), .Reset(a_rst), .SecondsLoad(a_load), .SecondsLoadValue(a_lv),
    .OverrunClear(a_clr), .evt(a_if.master), .Seconds(a_sec), .Overrun(a_ovr));

  // Instance B: 40 clocks/s, gap 2 (second boundary arrives mid-serialisation)
  logic b_rst, b_load, b_clr, b_ovr;
  logic [31:0] b_lv, b_sec;
  evg_v1_time_stamp_serializer_if b_if ();
  evg_v1_time_stamp_serializer #(.CLKS_PER_SEC(40), .BIT_GAP(2)) dut_b (
    .Clock(clk), .Reset(b_rst), .SecondsLoad(b_load), .SecondsLoadValue(b_lv),
    .OverrunClear(b_clr), .evt(b_if.master), .Seconds(b_sec), .Overrun(b_ovr));

  // Instance C: 100 clocks/s, gap 0
  logic c_rst, c_load, c_clr, c_ovr;
  logic [31:0] c_lv, c_sec;
  evg_v1_time_stamp_serializer_if c_if ();
  evg_v1_time_stamp_serializer #(.CLKS_PER_SEC(100), .BIT_GAP(0)) dut_c (
    .Clock(clk), .Reset(c_rst), .SecondsLoad(c_load), .SecondsLoadValue(c_lv),
    .OverrunClear(c_clr), .evt(c_if.master), .Seconds(c_sec), .Overrun(c_ovr));

  // Queue 0x7D then the 32 bit events of v, MSB first.
  task automatic push_value(input logic [31:0] v);
    exp_q.delete();
    exp_q.push_back(8'h7D);
    for (int i = 31; i >= 0; i--)
      exp_q.push_back(v[i] ? 8'h71 : 8'h70);
  endtask

  // Two reset cycles; returns just after a falling edge with reset released.
  task automatic reset_a();
    a_rst = 1'b1; a_load = 1'b0; a_clr = 1'b0; a_if.EvtReady = 1'b1;
    repeat (2) @(negedge clk);
    a_rst = 1'b0;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; a_load = 1'b0; a_clr = 1'b0; a_lv = '0; a_if.EvtReady = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (a_if.EvtValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", a_if.EvtValid); end
    n_cmp++; if (a_if.EvtCode !== 8'h00) begin n_bad++; $display("FAIL reset_code: got %h expected 00", a_if.EvtCode); end
    n_cmp++; if (a_sec !== 32'h0) begin n_bad++; $display("FAIL reset_seconds: got %h expected 0", a_sec); end
    n_cmp++; if (a_ovr !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b expected 0", a_ovr); end
  endtask

  // Load 0x0A (no event), first tick -> 0x7D then 0x0000000C, 3 cycles apart.
  task automatic test_serialize();
    int cyc, last;
    logic early;
    logic [7:0] e;
    reset_a();
    a_load = 1'b1; a_lv = 32'h0000000A;
    push_value(32'h0000000C);
    cyc = 0; last = 0; early = 1'b0;
    while (exp_q.size() > 0 && cyc < 400) begin
      @(negedge clk); cyc++;
      if (cyc == 1) a_load = 1'b0;
      if (a_if.EvtValid && cyc < 100) early = 1'b1;
      if (a_if.EvtValid && a_if.EvtReady) begin
        e = exp_q.pop_front();
        n_cmp++; if (a_if.EvtCode !== e) begin n_bad++; $display("FAIL ser_code: got %h expected %h at cycle %0d", a_if.EvtCode, e, cyc); end
        if (e == 8'h7D) begin
          n_cmp++; if (cyc != 100) begin n_bad++; $display("FAIL ser_latch_latency: got %0d expected 100", cyc); end
        end else begin
          n_cmp++; if (cyc - last != 3) begin n_bad++; $display("FAIL ser_spacing: got %0d expected 3", cyc - last); end
        end
        last = cyc;
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL ser_timeout: got %0d left expected 0", exp_q.size()); end
    n_cmp++; if (early) begin n_bad++; $display("FAIL ser_load_event: got 1 expected 0"); end
    n_cmp++; if (a_sec !== 32'h0B) begin n_bad++; $display("FAIL ser_seconds: got %h expected 0000000b", a_sec); end
    n_cmp++; if (a_ovr !== 1'b0) begin n_bad++; $display("FAIL ser_overrun: got %b expected 0", a_ovr); end
  endtask

  // 0xFFFFFFFE loaded, tick -> Seconds 0xFFFFFFFF, serialised 0.
  task automatic test_wrap();
    int cyc;
    logic [7:0] e;
    reset_a();
    a_load = 1'b1; a_lv = 32'hFFFFFFFE;
    push_value(32'h00000000);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      @(negedge clk); cyc++;
      if (cyc == 1) a_load = 1'b0;
      if (a_if.EvtValid && a_if.EvtReady) begin
        e = exp_q.pop_front();
        n_cmp++; if (a_if.EvtCode !== e) begin n_bad++; $display("FAIL wrap_code: got %h expected %h", a_if.EvtCode, e); end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL wrap_timeout: got %0d left expected 0", exp_q.size()); end
    n_cmp++; if (a_sec !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL wrap_seconds: got %h expected ffffffff", a_sec); end
  endtask

  // Load coincident with the tick: load wins, serialised value is load+1.
  task automatic test_load_tick();
    int cyc;
    logic [7:0] e;
    reset_a();
    a_lv = 32'h00000100;
    push_value(32'h00000101);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      @(negedge clk); cyc++;
      if (cyc == 99) a_load = 1'b1;
      if (cyc == 100) begin
        a_load = 1'b0;
        n_cmp++; if (a_sec !== 32'h100) begin n_bad++; $display("FAIL lt_seconds_at_tick: got %h expected 00000100", a_sec); end
      end
      if (a_if.EvtValid && a_if.EvtReady) begin
        e = exp_q.pop_front();
        n_cmp++; if (a_if.EvtCode !== e) begin n_bad++; $display("FAIL lt_code: got %h expected %h", a_if.EvtCode, e); end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL lt_timeout: got %0d left expected 0", exp_q.size()); end
    n_cmp++; if (a_sec !== 32'h100) begin n_bad++; $display("FAIL lt_seconds: got %h expected 00000100", a_sec); end
  endtask

  // Reset while 0x7D is presented; event withdrawn, next 0x7D after 100 cycles.
  task automatic test_reset_midop();
    int cyc, first;
    reset_a();
    a_if.EvtReady = 1'b0;
    cyc = 0;
    while (!a_if.EvtValid && cyc < 150) begin @(negedge clk); cyc++; end
    n_cmp++; if (a_if.EvtValid !== 1'b1) begin n_bad++; $display("FAIL rm_valid_before: got %b expected 1", a_if.EvtValid); end
    a_rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (a_if.EvtValid !== 1'b0) begin n_bad++; $display("FAIL rm_valid_after_reset: got %b expected 0", a_if.EvtValid); end
    n_cmp++; if (a_sec !== 32'h0) begin n_bad++; $display("FAIL rm_seconds: got %h expected 0", a_sec); end
    a_rst = 1'b0;
    cyc = 0; first = -1;
    while (first < 0 && cyc < 150) begin
      @(negedge clk); cyc++;
      if (a_if.EvtValid) first = cyc;
    end
    n_cmp++; if (first != 100) begin n_bad++; $display("FAIL rm_first_latch: got %0d expected 100", first); end
    n_cmp++; if (a_if.EvtCode !== 8'h7D) begin n_bad++; $display("FAIL rm_latch_code: got %h expected 7d", a_if.EvtCode); end
  endtask

  // 40-cycle second: 0x7D, 13 zero bits, then 0x7D again; Overrun set and cleared.
  task automatic test_overrun();
    int cyc, ntx;
    logic [7:0] e;
    b_rst = 1'b1; b_load = 1'b0; b_clr = 1'b0; b_lv = '0; b_if.EvtReady = 1'b1;
    repeat (2) @(negedge clk);
    b_rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'h7D);
    repeat (13) exp_q.push_back(8'h70);
    exp_q.push_back(8'h7D);
    cyc = 0; ntx = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (b_if.EvtValid && b_if.EvtReady) begin
        e = exp_q.pop_front();
        n_cmp++; if (b_if.EvtCode !== e) begin n_bad++; $display("FAIL ovr_code: got %h expected %h at cycle %0d", b_if.EvtCode, e, cyc); end
        if (ntx == 0) begin
          n_cmp++; if (b_ovr !== 1'b0) begin n_bad++; $display("FAIL ovr_early: got %b expected 0", b_ovr); end
        end
        ntx++;
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL ovr_timeout: got %0d left expected 0", exp_q.size()); end
    n_cmp++; if (b_ovr !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b expected 1", b_ovr); end
    b_clr = 1'b1;
    @(negedge clk);
    b_clr = 1'b0;
    n_cmp++; if (b_ovr !== 1'b0) begin n_bad++; $display("FAIL ovr_clear: got %b expected 0", b_ovr); end
    n_cmp++; if (b_sec !== 32'h2) begin n_bad++; $display("FAIL ovr_seconds: got %h expected 00000002", b_sec); end
  endtask

  // Gap 0: bits back to back; EvtReady low 5 cycles on the 0x71 bit.
  task automatic test_back_to_back();
    int cyc, ntx, last, stall;
    logic armed;
    logic [7:0] e, held;
    c_rst = 1'b1; c_load = 1'b0; c_clr = 1'b0; c_lv = '0; c_if.EvtReady = 1'b1;
    repeat (2) @(negedge clk);
    c_rst = 1'b0;
    push_value(32'h00000002);
    cyc = 0; ntx = 0; last = 0; stall = 0; armed = 1'b0; held = '0;
    while (exp_q.size() > 0 && cyc < 400) begin
      @(negedge clk); cyc++;
      if (armed && c_if.EvtValid) begin c_if.EvtReady = 1'b0; armed = 1'b0; end
      if (c_if.EvtValid && !c_if.EvtReady) begin
        stall++;
        if (stall == 1) begin
          held = c_if.EvtCode;
          n_cmp++; if (c_if.EvtCode !== exp_q[0]) begin n_bad++; $display("FAIL b2b_stall_code: got %h expected %h", c_if.EvtCode, exp_q[0]); end
        end else begin
          n_cmp++; if (c_if.EvtCode !== held) begin n_bad++; $display("FAIL b2b_stable: got %h expected %h", c_if.EvtCode, held); end
        end
        if (stall == 6) c_if.EvtReady = 1'b1;
      end
      if (c_if.EvtValid && c_if.EvtReady) begin
        e = exp_q.pop_front();
        n_cmp++; if (c_if.EvtCode !== e) begin n_bad++; $display("FAIL b2b_code: got %h expected %h at cycle %0d", c_if.EvtCode, e, cyc); end
        if (ntx == 0) begin
          n_cmp++; if (cyc != 100) begin n_bad++; $display("FAIL b2b_latch_latency: got %0d expected 100", cyc); end
        end
        if (ntx == 1) begin
          n_cmp++; if (cyc - last != 1) begin n_bad++; $display("FAIL b2b_gap0: got %0d expected 1", cyc - last); end
        end
        ntx++;
        last = cyc;
        if (ntx == 31) armed = 1'b1;
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL b2b_timeout: got %0d left expected 0", exp_q.size()); end
    n_cmp++; if (stall != 6) begin n_bad++; $display("FAIL b2b_stall_len: got %0d expected 6", stall); end
    repeat (10) begin
      @(negedge clk);
      if (c_if.EvtValid) ntx++;
    end
    n_cmp++; if (ntx != 33) begin n_bad++; $display("FAIL b2b_extra_events: got %0d expected 33", ntx); end
  endtask

  initial begin
    a_rst = 1'b1; a_load = 1'b0; a_clr = 1'b0; a_lv = '0; a_if.EvtReady = 1'b1;
    b_rst = 1'b1; b_load = 1'b0; b_clr = 1'b0; b_lv = '0; b_if.EvtReady = 1'b1;
    c_rst = 1'b1; c_load = 1'b0; c_clr = 1'b0; c_lv = '0; c_if.EvtReady = 1'b1;
    test_reset();
    test_serialize();
    test_wrap();
    test_load_tick();
    test_reset_midop();
    test_overrun();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
